// File: rtl/branch_cmp_iter.sv
// Iterative branch comparator: walks the operands CHUNK bits per cycle from the MSB
// chunk down and stops at the first differing chunk, then holds the result until consumed.
module branch_cmp_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       funct3,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             eq,
  output logic             lt,
  output logic             ltu,
  output logic             illegal
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0]       r_f3;
  logic [KW-1:0]    r_k;
  logic             r_taken, r_eq, r_lt, r_ltu, r_ill;

  logic [CHUNK-1:0] w_ca, w_cb, w_msk, w_sa, w_sb;
  logic             w_top, w_last, w_diff, w_lt, w_ltu, w_fin, w_accept;
  logic             w_eq_n, w_lt_n, w_ltu_n, w_take, w_ill;

  assign w_ca   = r_a[int'(r_k)*CHUNK +: CHUNK];
  assign w_cb   = r_b[int'(r_k)*CHUNK +: CHUNK];
  assign w_top  = (r_k == KW'(NCH-1));
  assign w_last = (r_k == '0);
  // Inverting the sign bit turns two's-complement order into plain magnitude order.
  assign w_msk  = w_top ? (CHUNK'(1) << (CHUNK-1)) : '0;
  assign w_sa   = w_ca ^ w_msk;
  assign w_sb   = w_cb ^ w_msk;
  assign w_diff = (w_ca != w_cb);
  assign w_lt   = (w_sa < w_sb);
  assign w_ltu  = (w_ca < w_cb);
  assign w_fin  = w_diff | w_last;

  assign w_accept = in_valid & in_ready & ~flush;

  assign w_eq_n  = ~w_diff;
  assign w_lt_n  = w_diff & w_lt;
  assign w_ltu_n = w_diff & w_ltu;
  assign w_ill   = (r_f3[2:1] == 2'b01);

  always_comb begin
    w_take = 1'b0;
    case (r_f3)
      3'b000:  w_take = w_eq_n;
      3'b001:  w_take = ~w_eq_n;
      3'b100:  w_take = w_lt_n;
      3'b101:  w_take = ~w_lt_n;
      3'b110:  w_take = w_ltu_n;
      3'b111:  w_take = ~w_ltu_n;
      default: w_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) w_next = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  if (in_valid)  w_next = S_BUSY;
        S_BUSY:  if (w_fin)     w_next = S_DONE;
        S_DONE:  if (out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_f3    <= '0;
      r_k     <= KW'(NCH-1);
      r_taken <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_ltu   <= 1'b0;
      r_ill   <= 1'b0;
    end else if (w_accept) begin
      r_a  <= a;
      r_b  <= b;
      r_f3 <= funct3;
      r_k  <= KW'(NCH-1);
    end else if (r_state == S_BUSY && !flush) begin
      if (w_fin) begin
        r_taken <= w_take & ~w_ill;
        r_eq    <= w_eq_n;
        r_lt    <= w_lt_n;
        r_ltu   <= w_ltu_n;
        r_ill   <= w_ill;
      end else begin
        r_k <= r_k - KW'(1);
      end
    end
  end

  assign taken   = r_taken;
  assign eq      = r_eq;
  assign lt      = r_lt;
  assign ltu     = r_ltu;
  assign illegal = r_ill;
endmodule

// File: tb/tb_branch_cmp_iter.sv
// Bench for branch_cmp_iter: directed cases on a 32/8 instance plus a random sweep of
// 32/8, 16/4 and 64/16 instances against an arithmetic golden compare model.
module tb_branch_cmp_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, out_ready;
  logic [2:0]  funct3;
  logic [63:0] a, b;
  logic [2:0]  iv, ir, ov, tk, eqo, lto, ltuo, ilo;
  int n_chk = 0, n_fail = 0;

  branch_cmp_iter #(.WIDTH(32), .CHUNK(8)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a[31:0]), .b(b[31:0]),
    .funct3(funct3), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
    .taken(tk[0]), .eq(eqo[0]), .lt(lto[0]), .ltu(ltuo[0]), .illegal(ilo[0]));
  branch_cmp_iter #(.WIDTH(16), .CHUNK(4)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[15:0]), .b(b[15:0]),
    .funct3(funct3), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
    .taken(tk[1]), .eq(eqo[1]), .lt(lto[1]), .ltu(ltuo[1]), .illegal(ilo[1]));
  branch_cmp_iter #(.WIDTH(64), .CHUNK(16)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b),
    .funct3(funct3), .flush(flush), .out_valid(ov[2]), .out_ready(out_ready),
    .taken(tk[2]), .eq(eqo[2]), .lt(lto[2]), .ltu(ltuo[2]), .illegal(ilo[2]));

  function automatic int wid(input int d);
    return (d == 0) ? 32 : (d == 1) ? 16 : 64;
  endfunction
  function automatic int chk(input int d);
    return (d == 0) ? 8 : (d == 1) ? 4 : 16;
  endfunction

  // {taken, eq, lt, ltu, illegal}
  function automatic logic [4:0] res(input int d);
    return {tk[d], eqo[d], lto[d], ltuo[d], ilo[d]};
  endfunction

  function automatic logic [4:0] golden(input int w, input logic [63:0] av, input logic [63:0] bv,
                                        input logic [2:0] f);
    logic [63:0] ua, ub;
    logic signed [63:0] sa, sb;
    logic e, l, lu, t, il;
    ua = (w == 64) ? av : (av & ((64'd1 << w) - 64'd1));
    ub = (w == 64) ? bv : (bv & ((64'd1 << w) - 64'd1));
    sa = $signed(av << (64 - w)) >>> (64 - w);
    sb = $signed(bv << (64 - w)) >>> (64 - w);
    e  = (ua == ub);
    lu = (ua < ub);
    l  = (sa < sb);
    il = (f == 3'b010) || (f == 3'b011);
    case (f)
      3'b000:  t = e;
      3'b001:  t = !e;
      3'b100:  t = l;
      3'b101:  t = !l;
      3'b110:  t = lu;
      3'b111:  t = !lu;
      default: t = 1'b0;
    endcase
    return {t, e, l, lu, il};
  endfunction

  // Edges from the accept edge (counted as 1) up to the edge after which out_valid is high.
  function automatic int exp_lat(input int w, input int c, input logic [63:0] av, input logic [63:0] bv);
    int nch;
    logic [63:0] m;
    nch = w / c;
    m = (64'd1 << c) - 64'd1;
    for (int k = nch - 1; k >= 0; k--)
      if ((((av ^ bv) >> (k * c)) & m) != 64'd0) return nch - k + 1;
    return nch + 1;
  endfunction

  task automatic start_txn(input int d, input logic [63:0] av, input logic [63:0] bv, input logic [2:0] f);
    @(negedge clk);
    a = av; b = bv; funct3 = f; iv[d] = 1'b1;
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; funct3 = 3'($urandom);
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 1;
    while (!ov[d] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ov[d]) lat = -1;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; iv = '0; a = '0; b = '0; funct3 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_chk++; if (ov !== 3'b000) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 000", ov); end
    n_chk++; if ({tk, eqo, lto, ltuo, ilo} !== 15'd0) begin n_fail++;
      $display("FAIL reset_results: got %b expected all zero", {tk, eqo, lto, ltuo, ilo}); end
    n_chk++; if (ir !== 3'b111) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 111", ir); end
  endtask

  task automatic test_beq_equal();
    int lat;
    start_txn(0, 64'h12345678, 64'h12345678, 3'b000);
    n_chk++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready: got %b expected 0", ir[0]); end
    wait_done(0, lat);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL beq_latency: got %0d expected 5", lat); end
    n_chk++; if (res(0) !== 5'b11000) begin n_fail++; $display("FAIL beq_result: got %b expected 11000", res(0)); end
    consume();
    n_chk++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL beq_consumed: got %b expected 0", ov[0]); end
  endtask

  task automatic test_signed_top();
    int lat;
    start_txn(0, 64'hFFFFFFFF, 64'h00000001, 3'b100);
    wait_done(0, lat);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL blt_latency: got %0d expected 2", lat); end
    n_chk++; if (res(0) !== 5'b10100) begin n_fail++; $display("FAIL blt_result: got %b expected 10100", res(0)); end
    consume();
    start_txn(0, 64'hFFFFFFFF, 64'h00000001, 3'b110);
    wait_done(0, lat);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL bltu_latency: got %0d expected 2", lat); end
    n_chk++; if (res(0) !== 5'b00100) begin n_fail++; $display("FAIL bltu_result: got %b expected 00100", res(0)); end
    consume();
  endtask

  task automatic test_bgeu_mid();
    int lat;
    start_txn(0, 64'h00000100, 64'h00000200, 3'b111);
    wait_done(0, lat);
    n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL bgeu_latency: got %0d expected 4", lat); end
    n_chk++; if (res(0) !== 5'b00110) begin n_fail++; $display("FAIL bgeu_result: got %b expected 00110", res(0)); end
    consume();
  endtask

  task automatic test_illegal_hold();
    int lat;
    start_txn(0, 64'h0, 64'h0, 3'b010);
    wait_done(0, lat);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL illegal_latency: got %0d expected 5", lat); end
    for (int i = 0; i < 3; i++) begin
      n_chk++; if ({ov[0], res(0)} !== 6'b101001) begin n_fail++;
        $display("FAIL illegal_hold cycle %0d: got %b expected 101001", i, {ov[0], res(0)}); end
      @(posedge clk);
      #1;
    end
    consume();
    n_chk++; if ({ov[0], ir[0]} !== 2'b01) begin n_fail++;
      $display("FAIL illegal_release: got %b expected 01", {ov[0], ir[0]}); end
  endtask

  task automatic test_flush();
    int lat;
    logic seen;
    seen = 1'b0;
    start_txn(0, 64'hA5A5A5A5, 64'hA5A5A5A5, 3'b000);
    seen |= ov[0];
    @(posedge clk);
    #1;
    seen |= ov[0];
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    seen |= ov[0];
    n_chk++; if ({seen, ir[0]} !== 2'b01) begin n_fail++;
      $display("FAIL flush_busy: got seen/ready %b expected 01", {seen, ir[0]}); end
    start_txn(0, 64'h0000_00FF, 64'h0000_0001, 3'b101);
    n_chk++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL flush_reaccept: got %b expected 0", ir[0]); end
    wait_done(0, lat);
    n_chk++; if (lat !== 5 || res(0) !== 5'b10000) begin n_fail++;
      $display("FAIL flush_next_txn: got lat %0d res %b expected lat 5 res 10000", lat, res(0)); end
    consume();
    @(negedge clk);
    iv[0] = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0; flush = 1'b0;
    n_chk++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL flush_blocks_accept: got %b expected 1", ir[0]); end
    start_txn(0, 64'h5, 64'h5, 3'b001);
    wait_done(0, lat);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; out_ready = 1'b0;
    n_chk++; if ({ov[0], ir[0]} !== 2'b01) begin n_fail++;
      $display("FAIL flush_done: got %b expected 01", {ov[0], ir[0]}); end
  endtask

  task automatic test_rst_busy();
    int lat;
    start_txn(0, 64'h77, 64'h77, 3'b000);
    wait_done(0, lat);
    consume();
    start_txn(0, 64'h1234, 64'h1234, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b1; flush = 1'b1; iv[0] = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; iv[0] = 1'b0; out_ready = 1'b0;
    n_chk++; if ({ir[0], ov[0], res(0)} !== 7'b1000000) begin n_fail++;
      $display("FAIL rst_busy: got %b expected 1000000", {ir[0], ov[0], res(0)}); end
    @(posedge clk);
    #1;
    n_chk++; if ({ir[0], ov[0]} !== 2'b10) begin n_fail++;
      $display("FAIL rst_busy_after: got %b expected 10", {ir[0], ov[0]}); end
  endtask

  task automatic test_random();
    int lat, el;
    logic [63:0] av, bv;
    logic [2:0] f;
    logic [4:0] er;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 60; i++) begin
        av = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: bv = {$urandom, $urandom};
          1: bv = av;
          2: bv = av ^ (64'd1 << $urandom_range(0, wid(d) - 1));
          default: bv = av ^ (64'd1 << (wid(d) - 1)) ^ (64'd1 << $urandom_range(0, wid(d) - 1));
        endcase
        f = 3'($urandom_range(0, 7));
        er = golden(wid(d), av, bv, f);
        el = exp_lat(wid(d), chk(d), av, bv);
        start_txn(d, av, bv, f);
        wait_done(d, lat);
        n_chk++; if (lat !== el) begin n_fail++;
          $display("FAIL rand_latency w%0d f%b a=%h b=%h: got %0d expected %0d", wid(d), f, av, bv, lat, el); end
        n_chk++; if (res(d) !== er) begin n_fail++;
          $display("FAIL rand_result w%0d f%b a=%h b=%h: got %b expected %b", wid(d), f, av, bv, res(d), er); end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        consume();
      end
    end
  endtask

  initial begin
    test_reset();
    test_beq_equal();
    test_signed_top();
    test_bgeu_mid();
    test_illegal_hold();
    test_flush();
    test_rst_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
